// File: rtl/wash_pkg.sv
// ---------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the wash controller and its phase timer.
//   phase_e         : 3-bit phase encoding, also used by the wash FSM
//   DEF_*           : default timing constants for the phase timer
//   next_phase()    : phase that a sampled load strobe moves to
// ---------------------------------------------------------------------------
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_e;

  localparam int DEF_TICKS_PER_SEC = 50_000_000;
  localparam int DEF_SEC_W         = 10;
  localparam int DEF_FILL_SEC      = 120;
  localparam int DEF_WASH_SEC      = 300;
  localparam int DEF_RINSE_SEC     = 120;
  localparam int DEF_SPIN_SEC      = 60;

  // Phase sequence on a load strobe. RINSE either loops back to WASH for a
  // second wash or moves on to SPIN. SPIN leaves by itself, so a strobe there
  // keeps the phase unchanged.
  function automatic phase_e next_phase(input phase_e cur, input logic dbl);
    phase_e nxt;
    nxt = cur;
    case (cur)
      PH_IDLE:  nxt = PH_FILL;
      PH_FILL:  nxt = PH_WASH;
      PH_WASH:  nxt = PH_RINSE;
      PH_RINSE: nxt = dbl ? PH_WASH : PH_SPIN;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// ---------------------------------------------------------------------------
// wash_phase_timer_if
// Handshake between the wash FSM (master) and the phase timer (slave).
//   state_time    : FSM -> timer, load strobe / advance phase
//   double_time   : FSM -> timer, in RINSE selects WASH instead of SPIN
//   pause         : FSM -> timer, freeze countdown (WASH_TIMER_PAUSE_EN only)
//   timer_finish  : timer -> FSM, one-cycle expiry pulse
//   phase         : timer -> FSM, current phase
//   remaining_sec : timer -> FSM, seconds left in the phase
//   busy          : timer -> FSM, phase != IDLE
//   proto_err     : timer -> FSM, sticky protocol violation flag
// ---------------------------------------------------------------------------
interface wash_phase_timer_if #(
  parameter int SEC_W = wash_pkg::DEF_SEC_W
) ();

  logic             state_time;
  logic             double_time;
  logic             timer_finish;
  logic [2:0]       phase;
  logic [SEC_W-1:0] remaining_sec;
  logic             busy;
  logic             proto_err;

`ifdef WASH_TIMER_PAUSE_EN
  logic             pause;

  modport master (
    output state_time, double_time, pause,
    input  timer_finish, phase, remaining_sec, busy, proto_err
  );

  modport slave (
    input  state_time, double_time, pause,
    output timer_finish, phase, remaining_sec, busy, proto_err
  );
`else
  modport master (
    output state_time, double_time,
    input  timer_finish, phase, remaining_sec, busy, proto_err
  );

  modport slave (
    input  state_time, double_time,
    output timer_finish, phase, remaining_sec, busy, proto_err
  );
`endif

endinterface

// File: rtl/wash_phase_timer_sec_tick_gen.sv
// ---------------------------------------------------------------------------
// sec_tick_gen
// Prescaler that divides clk_fsm down to a one-per-second tick.
//   clk_fsm : clock
//   rst_n   : asynchronous active-low reset
//   clear   : restart the second from zero (has priority over enable)
//   enable  : advance the prescaler this cycle
//   tick    : high in the cycle whose edge completes a second
// ---------------------------------------------------------------------------
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000,
  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic clk_fsm,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count;

  // The tick is combinational so the seconds counter updates on the very edge
  // at which the prescaler wraps.
  assign tick = enable && !clear && (count == LAST);

  // Prescaler: cleared on a phase load, otherwise counts 0..TICKS_PER_SEC-1
  // while enabled and holds when disabled.
  always_ff @(posedge clk_fsm or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// ---------------------------------------------------------------------------
// wash_phase_timer
// Timer end of the wash controller handshake. Tracks the active wash phase,
// counts that phase's duration in seconds and returns a one-cycle
// timer_finish pulse when the count expires.
//   clk_fsm : clock shared with the wash FSM
//   rst_n   : asynchronous active-low reset
//   tmr     : wash_phase_timer_if.slave (strobes in, status out)
// Optional feature macro: WASH_TIMER_PAUSE_EN adds the pause input that
// freezes the countdown.
// All outputs are registered.
// ---------------------------------------------------------------------------
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int SEC_W         = DEF_SEC_W,
  parameter int FILL_SEC      = DEF_FILL_SEC,
  parameter int WASH_SEC      = DEF_WASH_SEC,
  parameter int RINSE_SEC     = DEF_RINSE_SEC,
  parameter int SPIN_SEC      = DEF_SPIN_SEC
) (
  input  logic             clk_fsm,
  input  logic             rst_n,
  wash_phase_timer_if.slave tmr
);

  // A zero duration would never produce a finish pulse, so it becomes 1 s.
  localparam logic [SEC_W-1:0] FILL_LD  = (FILL_SEC  == 0) ? SEC_W'(1) : SEC_W'(FILL_SEC);
  localparam logic [SEC_W-1:0] WASH_LD  = (WASH_SEC  == 0) ? SEC_W'(1) : SEC_W'(WASH_SEC);
  localparam logic [SEC_W-1:0] RINSE_LD = (RINSE_SEC == 0) ? SEC_W'(1) : SEC_W'(RINSE_SEC);
  localparam logic [SEC_W-1:0] SPIN_LD  = (SPIN_SEC  == 0) ? SEC_W'(1) : SEC_W'(SPIN_SEC);

  function automatic logic [SEC_W-1:0] load_value(input phase_e p);
    logic [SEC_W-1:0] v;
    v = '0;
    case (p)
      PH_FILL:  v = FILL_LD;
      PH_WASH:  v = WASH_LD;
      PH_RINSE: v = RINSE_LD;
      PH_SPIN:  v = SPIN_LD;
      default:  v = '0;
    endcase
    return v;
  endfunction

  phase_e           phase_q;
  logic [SEC_W-1:0] remaining_q;
  logic             finish_q;
  logic             busy_q;
  logic             err_q;

  phase_e           phase_tgt;
  logic             advance;
  logic             violation;
  logic             pause_act;
  logic             count_en;
  logic             tick;

`ifdef WASH_TIMER_PAUSE_EN
  assign pause_act = tmr.pause;
`else
  assign pause_act = 1'b0;
`endif

  // Strobe decode. SPIN ignores strobes because it returns to IDLE by itself.
  // A strobe while seconds remain is still honoured but flagged, as is any
  // double_time that does not accompany a strobe in RINSE.
  always_comb begin
    phase_tgt = next_phase(phase_q, tmr.double_time);
    advance   = tmr.state_time && (phase_q != PH_SPIN);
    violation = (tmr.state_time && ((remaining_q != '0) || (phase_q == PH_SPIN))) ||
                (tmr.double_time && (!tmr.state_time || (phase_q != PH_RINSE)));
  end

  // The prescaler only runs while there is time left to count down.
  assign count_en = (remaining_q != '0) && !pause_act;

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk_fsm (clk_fsm),
    .rst_n   (rst_n),
    .clear   (advance),
    .enable  (count_en),
    .tick    (tick)
  );

  // Phase FSM and seconds counter. A load has priority over everything, so a
  // strobe in the finish cycle reloads cleanly. SPIN drops to IDLE on the edge
  // after its finish pulse. timer_finish is a pulse: it is set only on the
  // edge where the count goes 1 -> 0 and cleared on every other edge.
  always_ff @(posedge clk_fsm or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_IDLE;
      remaining_q <= '0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (violation) begin
        err_q <= 1'b1;
      end
      if (advance) begin
        phase_q     <= phase_tgt;
        remaining_q <= load_value(phase_tgt);
        busy_q      <= 1'b1;
      end else if ((phase_q == PH_SPIN) && finish_q) begin
        phase_q     <= PH_IDLE;
        remaining_q <= '0;
        busy_q      <= 1'b0;
      end else if (tick) begin
        remaining_q <= remaining_q - 1'b1;
        if (remaining_q == SEC_W'(1)) begin
          finish_q <= 1'b1;
        end
      end
    end
  end

  assign tmr.phase         = phase_q;
  assign tmr.remaining_sec = remaining_q;
  assign tmr.timer_finish  = finish_q;
  assign tmr.busy          = busy_q;
  assign tmr.proto_err     = err_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_wash_phase_timer
// Self-checking bench for wash_phase_timer. A behavioural model tracks each
// phase as an absolute deadline (edge number of the expiry) and derives the
// remaining seconds arithmetically from it. Directed scenarios come first,
// then a long randomized run. Build with WASH_TIMER_PAUSE_EN to cover pause.
// ---------------------------------------------------------------------------
module tb_wash_phase_timer;

  localparam int T     = 4;
  localparam int SEC_W = 10;
  localparam int FILL  = 3;
  localparam int WASH  = 5;
  localparam int RINSE = 2;
  localparam int SPIN  = 2;

  logic clk_fsm = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk_fsm = ~clk_fsm;

  wash_phase_timer_if #(.SEC_W(SEC_W)) bus ();

  wash_phase_timer #(
    .TICKS_PER_SEC (T),
    .SEC_W         (SEC_W),
    .FILL_SEC      (FILL),
    .WASH_SEC      (WASH),
    .RINSE_SEC     (RINSE),
    .SPIN_SEC      (SPIN)
  ) dut (
    .clk_fsm (clk_fsm),
    .rst_n   (rst_n),
    .tmr     (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  int     m_phase;
  bit     m_valid;
  longint m_now;
  longint m_deadline;
  bit     m_err;
  bit     m_fin;
  int     m_rem;

  function automatic int dur(input int p);
    case (p)
      1:       return FILL;
      2:       return WASH;
      3:       return RINSE;
      4:       return SPIN;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errs++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("phase", int'(bus.phase), m_phase);
    checkOutput("remaining_sec", int'(bus.remaining_sec), m_rem);
    checkOutput("timer_finish", int'(bus.timer_finish), int'(m_fin));
    checkOutput("busy", int'(bus.busy), (m_phase != 0) ? 1 : 0);
    checkOutput("proto_err", int'(bus.proto_err), int'(m_err));
  endtask

  // One clock edge of the reference model, using the inputs sampled there.
  task automatic modelStep(input bit st, input bit dt, input bit ps);
    int rem_pre;
    bit fin_pre;
    m_now++;
    rem_pre = m_rem;
    fin_pre = m_fin;
    if ((st && (rem_pre > 0 || m_phase == 4)) || (dt && (!st || m_phase != 3)))
      m_err = 1'b1;
    if (st && m_phase != 4) begin
      case (m_phase)
        0:       m_phase = 1;
        1:       m_phase = 2;
        2:       m_phase = 3;
        default: m_phase = dt ? 2 : 4;
      endcase
      m_deadline = m_now + longint'(dur(m_phase) * T);
      m_valid    = 1'b1;
    end else if (m_phase == 4 && fin_pre) begin
      m_phase = 0;
      m_valid = 1'b0;
    end else if (ps && rem_pre > 0) begin
      m_deadline++;
    end
    if (m_valid && m_now < m_deadline)
      m_rem = int'((m_deadline - m_now + T - 1) / T);
    else
      m_rem = 0;
    m_fin = m_valid && (m_now == m_deadline);
  endtask

  task automatic applyStimulus(input bit st, input bit dt, input bit ps);
    bit ps_eff;
    ps_eff = ps;
`ifndef WASH_TIMER_PAUSE_EN
    ps_eff = 1'b0;
`endif
    @(negedge clk_fsm);
    bus.state_time  = st;
    bus.double_time = dt;
`ifdef WASH_TIMER_PAUSE_EN
    bus.pause       = ps_eff;
`endif
    @(posedge clk_fsm);
    modelStep(st, dt, ps_eff);
    #1;
    checkAll();
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic doReset();
    @(negedge clk_fsm);
    bus.state_time  = 1'b0;
    bus.double_time = 1'b0;
`ifdef WASH_TIMER_PAUSE_EN
    bus.pause       = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    m_phase = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_fin   = 1'b0;
    m_rem   = 0;
    checkAll();
    @(posedge clk_fsm);
    @(negedge clk_fsm);
    rst_n = 1'b1;
  endtask

  // Idle cycles until the finish pulse, returning edges since the load edge.
  task automatic waitFinish(input string tag, output int cycles);
    cycles = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      cycles++;
    end while (!bus.timer_finish && cycles < 200);
    checkOutput(tag, int'(bus.timer_finish), 1);
  endtask

  task automatic waitRemaining(input int target);
    int guard;
    guard = 0;
    while (int'(bus.remaining_sec) != target && guard < 100) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("reach_remaining", int'(bus.remaining_sec), target);
  endtask

  initial begin
    int c;
    int r;
    bit st, dt, ps;

    bus.state_time  = 1'b0;
    bus.double_time = 1'b0;
`ifdef WASH_TIMER_PAUSE_EN
    bus.pause       = 1'b0;
`endif
    m_now      = 0;
    m_deadline = 0;

    // Reset, then a strobe in IDLE loads FILL
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fill_phase", int'(bus.phase), 1);
    checkOutput("fill_load", int'(bus.remaining_sec), 3);
    waitFinish("fill_finish", c);
    checkOutput("fill_latency", c, 12);

    // Full cycle with strobes at each finish, double_time=0
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFinish("wash_finish", c);
    checkOutput("wash_latency", c, 20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFinish("rinse_finish", c);
    checkOutput("rinse_latency", c, 8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("spin_phase", int'(bus.phase), 4);
    waitFinish("spin_finish", c);
    checkOutput("spin_latency", c, 8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_spin_phase", int'(bus.phase), 0);
    checkOutput("after_spin_busy", int'(bus.busy), 0);
    checkOutput("legal_cycle_err", int'(bus.proto_err), 0);

    // RINSE with double_time at finish goes back to WASH
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFinish("d_fill", c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFinish("d_wash", c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFinish("d_rinse", c);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("double_phase", int'(bus.phase), 2);
    checkOutput("double_load", int'(bus.remaining_sec), 5);
    waitFinish("d_wash2", c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("double_rinse_again", int'(bus.phase), 3);
    checkOutput("double_err", int'(bus.proto_err), 0);

    // Reset mid-WASH at 3 s remaining
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFinish("r_fill", c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitRemaining(3);
    doReset();
    checkOutput("rst_phase", int'(bus.phase), 0);
    checkOutput("rst_finish", int'(bus.timer_finish), 0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    // Early strobe mid-FILL is honoured and flagged
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitRemaining(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("early_phase", int'(bus.phase), 2);
    checkOutput("early_load", int'(bus.remaining_sec), 5);
    checkOutput("early_err", int'(bus.proto_err), 1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("early_err_sticky", int'(bus.proto_err), 1);

`ifdef WASH_TIMER_PAUSE_EN
    // Ten paused cycles mid-WASH delay the finish by exactly ten cycles
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFinish("p_fill", c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pause_start_rem", int'(bus.remaining_sec), 4);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pause_frozen_rem", int'(bus.remaining_sec), 4);
    waitFinish("p_wash", c);
    checkOutput("pause_delay", 15 + c, 30);
`endif

    // Randomized run, biased towards strobes at the legal reload point
    doReset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599) == 0) begin
        doReset();
      end else begin
        r = int'($urandom_range(99));
        if (m_fin)             st = (r < 75);
        else if (m_phase == 0) st = (r < 15);
        else                   st = (r < 2);
        if (st && m_phase == 3) dt = 1'($urandom_range(1));
        else                    dt = ($urandom_range(99) < 2);
        ps = ($urandom_range(99) < 10);
        applyStimulus(st, dt, ps);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
